// File: rtl/tatzel_sar_ctrl_if.sv
// Handshake and data bundle between the SAR controller and its tile/DAC/comparator surroundings.
interface tatzel_sar_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             start;
    logic             cmp_in;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             valid;

    modport master (
        output ena, start, cmp_in,
        input  dac_code, busy, done, result, valid
    );

    modport slave (
        input  ena, start, cmp_in,
        output dac_code, busy, done, result, valid
    );
endinterface

// File: rtl/tatzel_sar_ctrl.sv
// Successive-approximation controller: binary search on the DAC code using a
// synchronised comparator, one bit per SETTLE+SYNC_STAGES+1 cycles.
module tatzel_sar_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SETTLE      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    tatzel_sar_ctrl_if.slave  sar
);
    localparam int L  = SETTLE + SYNC_STAGES;
    localparam int CW = $clog2(L) + 1;
    localparam int IW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_DECIDE = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [WIDTH-1:0]       dac_q, dac_d;
    logic [WIDTH-1:0]       res_q, res_d;
    logic [IW-1:0]          i_q, i_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   valid_q, valid_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cmp_s;

    assign cmp_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        dac_d   = dac_q;
        res_d   = res_q;
        i_d     = i_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        // Tile disable wins over every state and suppresses the done pulse.
        if (!sar.ena) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            dac_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sar.start) begin
                        dac_d            = '0;
                        dac_d[WIDTH-1]   = 1'b1;
                        i_d              = IW'(WIDTH - 1);
                        cnt_d            = '0;
                        busy_d           = 1'b1;
                        state_d          = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(L - 1)) state_d = S_DECIDE;
                end
                S_DECIDE: begin
                    if (!cmp_s) dac_d[i_q] = 1'b0;
                    if (i_q != '0) begin
                        dac_d[i_q - IW'(1)] = 1'b1;
                        i_d                 = i_q - IW'(1);
                        cnt_d               = '0;
                        state_d             = S_SETTLE;
                    end else begin
                        // Bit 0 is resolved in this same edge, so take it from dac_d.
                        res_d   = dac_d;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        dac_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dac_q   <= '0;
            res_q   <= '0;
            i_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            dac_q   <= dac_d;
            res_q   <= res_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sar.cmp_in};
        end
    end

    assign sar.dac_code = dac_q;
    assign sar.busy     = busy_q;
    assign sar.done     = done_q;
    assign sar.result   = res_q;
    assign sar.valid    = valid_q;
endmodule

// File: tb/tb_tatzel_sar_ctrl.sv
// Bench for tatzel_sar_ctrl: ideal comparator with one-cycle delay, an
// edge-count reference model checked every cycle, plus directed literal checks.
module tb_tatzel_sar_ctrl;
  localparam int W   = 8;
  localparam int ST  = 2;
  localparam int SY  = 2;
  localparam int L   = ST + SY;
  localparam int TOT = W * (L + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tatzel_sar_ctrl_if #(.WIDTH(W)) sif();

  tatzel_sar_ctrl #(.WIDTH(W), .SETTLE(ST), .SYNC_STAGES(SY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sar   (sif.slave)
  );

  int errors = 0;
  int checks = 0;
  int T      = 0;

  // Analog comparator: sees the DAC code one cycle late.
  always @(posedge clk) sif.cmp_in <= (T >= int'(sif.dac_code));

  // Reference model: counts edges since acceptance; ideal binary search gives T.
  bit m_act   = 1'b0;
  int m_ph    = 0;
  int m_tc    = 0;
  int e_res   = 0;
  bit e_done  = 1'b0;
  bit e_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_ph <= 0; e_res <= 0; e_done <= 1'b0; e_valid <= 1'b0;
    end else begin
      e_done <= 1'b0;
      if (!sif.ena) m_act <= 1'b0;
      else if (m_act) begin
        m_ph <= m_ph + 1;
        if (m_ph + 1 == TOT) begin
          m_act <= 1'b0; e_res <= m_tc; e_valid <= 1'b1; e_done <= 1'b1;
        end
      end else if (sif.start) begin
        m_act <= 1'b1; m_ph <= 0; m_tc <= T;
      end
    end
  end

  // Trial code for step k: bits above the trial bit come from the target, trial bit set.
  function automatic int trial(int tc, int k);
    int sh;
    sh = W - k;
    return ((tc >> sh) << sh) | (1 << (W - 1 - k));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of {dac_code, busy, done, result, valid}.
  initial begin
    int ed;
    forever begin
      @(negedge clk);
      ed = m_act ? trial(m_tc, m_ph / (L + 1)) : 0;
      chk("cycle{dac,busy,done,res,valid}",
          {13'd0, sif.dac_code, sif.busy, sif.done, sif.result, sif.valid},
          {13'd0, 8'(ed), m_act, e_done, 8'(e_res), e_valid});
    end
  end

  task automatic start_conv(input int t);
    @(negedge clk);
    T = t;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sif.done && n < 200);
    if (!sif.done) chk("done_timeout", {31'd0, sif.done}, 32'd1);
  endtask

  task automatic count_done(input int cyc, output int nd);
    nd = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (sif.done) nd++;
    end
  endtask

  initial begin
    int n, nd, t;
    logic [7:0] seq[$];
    logic [7:0] lit[8];
    lit = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    sif.ena = 1'b1;
    sif.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dac", sif.dac_code, 0);
    chk("rst_busy", sif.busy, 0);
    chk("rst_done", sif.done, 0);
    chk("rst_result", sif.result, 0);
    chk("rst_valid", sif.valid, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T=0xA5: trial sequence and 40-edge latency
    start_conv(8'hA5);
    seq.push_back(sif.dac_code);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (sif.busy && seq[$] != sif.dac_code) seq.push_back(sif.dac_code);
    end while (!sif.done && n < 200);
    chk("a5_latency", n, 40);
    chk("a5_seq_len", seq.size(), 8);
    for (int k = 0; k < 8 && k < seq.size(); k++) chk("a5_seq", seq[k], lit[k]);
    chk("a5_result", sif.result, 8'hA5);
    chk("a5_valid", sif.valid, 1);
    @(negedge clk);
    chk("a5_done_width", sif.done, 0);

    // Endpoints
    start_conv(8'h00);
    wait_done(n);
    chk("t00_latency", n, 40);
    chk("t00_result", sif.result, 8'h00);
    @(negedge clk);
    chk("t00_done_width", sif.done, 0);
    start_conv(8'hFF);
    wait_done(n);
    chk("tff_result", sif.result, 8'hFF);
    @(negedge clk);
    chk("tff_done_width", sif.done, 0);

    // start re-pulsed while busy is ignored
    start_conv(8'h3C);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      sif.start = (n == 5 || n == 20);
    end while (!sif.done && n < 200);
    sif.start = 1'b0;
    chk("3c_latency", n, 40);
    chk("3c_result", sif.result, 8'h3C);
    count_done(45, nd);
    chk("3c_no_second_done", nd, 0);
    chk("3c_idle", sif.busy, 0);

    // start held high: back-to-back conversions 41 edges apart
    @(negedge clk);
    T = 8'h12;
    sif.start = 1'b1;
    wait_done(n);
    chk("held_res1", sif.result, 8'h12);
    T = 8'h81;
    wait_done(n);
    sif.start = 1'b0;
    chk("held_spacing", n, 41);
    chk("held_res2", sif.result, 8'h81);
    repeat (3) @(negedge clk);

    // ena abort at edge 17 keeps the prior result
    start_conv(8'h5A);
    wait_done(n);
    chk("ena_prior", sif.result, 8'h5A);
    start_conv(8'h77);
    repeat (16) @(negedge clk);
    chk("ena_busy_before", sif.busy, 1);
    sif.ena = 1'b0;
    @(negedge clk);
    chk("ena_busy_after", sif.busy, 0);
    chk("ena_dac_after", sif.dac_code, 0);
    count_done(50, nd);
    chk("ena_no_done", nd, 0);
    chk("ena_result_kept", sif.result, 8'h5A);
    chk("ena_valid_kept", sif.valid, 1);
    sif.ena = 1'b1;

    // Asynchronous reset mid-conversion
    start_conv(8'h44);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dac", sif.dac_code, 0);
    chk("arst_busy", sif.busy, 0);
    chk("arst_result", sif.result, 0);
    chk("arst_valid", sif.valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_conv(8'h33);
    wait_done(n);
    chk("arst_fresh", sif.result, 8'h33);

    // Randomised conversions, some aborted by ena
    repeat (10) begin
      t = int'($urandom_range(0, 255));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      start_conv(t);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 38)) @(negedge clk);
        sif.ena = 1'b0;
        @(negedge clk);
        sif.ena = 1'b1;
      end else begin
        wait_done(n);
        chk("rnd_latency", n, 40);
        chk("rnd_result", sif.result, t);
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
